vga_timing_overlay: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates H/V timing from parameters, with selectable sync polarity, pixel coordinates and a registered blank signal.
- Draws an optional vertical centre line whose thickness is stepped at run time by the plus/minus inputs.
- Sits between the 25 MHz pixel PLL and the DAC pins; drives vga_rgb/vga_hs/vga_vs/vga_blank_n.

---
 rtl/vga_timing_overlay_if.sv | 28 ++
 rtl/vga_timing_overlay.sv | 144 ++++++++++++++
 tb/tb_vga_timing_overlay.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_overlay_if.sv
// Pixel-side bundle of vga_timing_overlay: overlay controls in, DAC pins and aligned coordinates out.
// There is no valid/ready here. Every signal is a plain level. The three controls are sampled on every clock, and the outputs change once per pixel clock.
interface vga_timing_overlay_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int TW = 4
);
  logic          show_cl;
  logic          plus_thick;
  logic          minus_thick;
  logic [23:0]   vga_rgb;
  logic          vga_hs;
  logic          vga_vs;
  logic          vga_blank_n;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [TW-1:0] thick;

  modport master (
    output show_cl, plus_thick, minus_thick,
    input  vga_rgb, vga_hs, vga_vs, vga_blank_n, pix_x, pix_y, thick
  );

  modport slave (
    input  show_cl, plus_thick, minus_thick,
    output vga_rgb, vga_hs, vga_vs, vga_blank_n, pix_x, pix_y, thick
  );
endinterface

// File: rtl/vga_timing_overlay.sv
// Parametrised VGA timing generator with a run-time adjustable vertical centre line overlay.
// Optional macro VGA_TEST_PATTERN_EN replaces the flat background with 8 colour bars.
module vga_timing_overlay #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          SYNC_POL  = 0,
  parameter int          MAX_THICK = 15,
  parameter logic [23:0] LINE_RGB  = 24'hFF0000,
  parameter logic [23:0] BG_RGB    = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_overlay_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int TW = $clog2(MAX_THICK + 1);
  localparam int CW = XW + 1;
  localparam int VW = YW + 1;
  localparam logic POL = 1'(SYNC_POL);

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_MID    = CW'(H_ACTIVE / 2);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic [TW-1:0] staged;
  logic [TW-1:0] thick_q;
  logic          plus_prev;
  logic          minus_prev;

  logic          last_h, last_v, frame_start;
  logic          plus_rise, minus_rise;
  logic [CW-1:0] hx, x_lo, x_hi;
  logic [VW-1:0] vy;
  logic          active, hs_on, vs_on, on_line;
  logic [23:0]   bg;
  logic [23:0]   pix_rgb;

  assign last_h      = (h_cnt == XW'(H_TOTAL - 1));
  assign last_v      = (v_cnt == YW'(V_TOTAL - 1));
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign plus_rise   = bus.plus_thick & ~plus_prev;
  assign minus_rise  = bus.minus_thick & ~minus_prev;

  // Widen by one bit so x_lo + thick can never wrap.
  assign hx      = {1'b0, h_cnt};
  assign vy      = {1'b0, v_cnt};
  assign x_lo    = H_MID - CW'(thick_q >> 1);
  assign x_hi    = x_lo + CW'(thick_q);
  assign active  = (hx < H_ACT_C) && (vy < V_ACT_C);
  assign hs_on   = (hx >= HS_START) && (hx < HS_END);
  assign vs_on   = (vy >= VS_START) && (vy < VS_END);
  assign on_line = (hx >= x_lo) && (hx < x_hi);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BW = CW + 3;
  logic [BW-1:0] hx8;
  logic [2:0]    bar;

  // bar = floor(h*8 / H_ACTIVE) without a divider: count thresholds passed.
  always_comb begin
    hx8 = {hx, 3'b000};
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hx8 >= BW'(k * H_ACTIVE)) bar = 3'(k);
    end
  end

  always_comb begin
    bg = 24'h000000;
    case (bar)
      3'd0: bg = 24'hFFFFFF;
      3'd1: bg = 24'hFFFF00;
      3'd2: bg = 24'h00FFFF;
      3'd3: bg = 24'h00FF00;
      3'd4: bg = 24'hFF00FF;
      3'd5: bg = 24'hFF0000;
      3'd6: bg = 24'h0000FF;
      default: bg = 24'h000000;
    endcase
  end
`else
  assign bg = BG_RGB;
`endif

  always_comb begin
    pix_rgb = bg;
    if (!active)                    pix_rgb = 24'h000000;
    else if (bus.show_cl && on_line) pix_rgb = LINE_RGB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      staged          <= TW'(1);
      thick_q         <= TW'(1);
      plus_prev       <= 1'b0;
      minus_prev      <= 1'b0;
      bus.vga_rgb     <= 24'h000000;
      bus.vga_hs      <= ~POL;
      bus.vga_vs      <= ~POL;
      bus.vga_blank_n <= 1'b0;
      bus.pix_x       <= '0;
      bus.pix_y       <= '0;
    end else begin
      h_cnt <= last_h ? '0 : h_cnt + XW'(1);
      if (last_h) v_cnt <= last_v ? '0 : v_cnt + YW'(1);

      plus_prev  <= bus.plus_thick;
      minus_prev <= bus.minus_thick;
      if (plus_rise && !minus_rise && staged != TW'(MAX_THICK))
        staged <= staged + TW'(1);
      else if (minus_rise && !plus_rise && staged != TW'(1))
        staged <= staged - TW'(1);

      // Thickness only changes at the frame boundary so a frame is never torn.
      if (frame_start) thick_q <= staged;

      bus.vga_rgb     <= pix_rgb;
      bus.vga_hs      <= hs_on ? POL : ~POL;
      bus.vga_vs      <= vs_on ? POL : ~POL;
      bus.vga_blank_n <= active;
      bus.pix_x       <= h_cnt;
      bus.pix_y       <= v_cnt;
    end
  end

  assign bus.thick = thick_q;
endmodule

// File: tb/tb_vga_timing_overlay.sv
// Bench for vga_timing_overlay on a 16x8 mode; optional macro VGA_TEST_PATTERN_EN enables bar checks.
module tb_vga_timing_overlay;
  localparam int H_ACT = 16, H_FP = 2, H_SYN = 3, H_BP = 3;
  localparam int V_ACT = 8,  V_FP = 1, V_SYN = 2, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int MAXT = 3;
  localparam logic POL = 1'b0;
  localparam logic [23:0] LINE = 24'hFF0000;
  localparam logic [23:0] BG   = 24'h101010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  vga_timing_overlay_if #(.XW(5), .YW(4), .TW(2)) bus ();

  vga_timing_overlay #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
    .SYNC_POL(0), .MAX_THICK(MAXT), .LINE_RGB(LINE), .BG_RGB(BG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

`ifdef VGA_TEST_PATTERN_EN
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  // ---------------- behavioural model ----------------
  function automatic logic [23:0] model_rgb(int x, int y, int t, logic sc);
    int lo;
    if (!(x < H_ACT && y < V_ACT)) return 24'h000000;
    lo = H_ACT / 2 - t / 2;
    if (sc && x >= lo && x < lo + t) return LINE;
`ifdef VGA_TEST_PATTERN_EN
    return bars[(x * 8) / H_ACT];
`else
    return BG;
`endif
  endfunction

  int m_x, m_y, m_thick, m_staged;
  logic m_pp, m_mp, m_valid = 1'b0;
  logic [23:0] e_rgb;
  logic e_hs, e_vs, e_blank;
  int e_px, e_py, e_thick;

  always @(posedge clk) begin
    if (rst) begin
      m_x <= 0; m_y <= 0; m_thick <= 1; m_staged <= 1; m_pp <= 1'b0; m_mp <= 1'b0;
      e_rgb <= 24'h0; e_hs <= ~POL; e_vs <= ~POL; e_blank <= 1'b0;
      e_px <= 0; e_py <= 0; e_thick <= 1; m_valid <= 1'b1;
    end else begin
      e_px    <= m_x;
      e_py    <= m_y;
      e_blank <= (m_x < H_ACT) && (m_y < V_ACT);
      e_hs    <= (m_x >= H_ACT + H_FP && m_x < H_ACT + H_FP + H_SYN) ? POL : ~POL;
      e_vs    <= (m_y >= V_ACT + V_FP && m_y < V_ACT + V_FP + V_SYN) ? POL : ~POL;
      e_rgb   <= model_rgb(m_x, m_y, m_thick, bus.show_cl);
      m_x     <= (m_x + 1) % H_TOT;
      if (m_x == H_TOT - 1) m_y <= (m_y + 1) % V_TOT;
      m_pp <= bus.plus_thick;
      m_mp <= bus.minus_thick;
      if ((bus.plus_thick && !m_pp) && !(bus.minus_thick && !m_mp))
        m_staged <= (m_staged < MAXT) ? m_staged + 1 : MAXT;
      else if ((bus.minus_thick && !m_mp) && !(bus.plus_thick && !m_pp))
        m_staged <= (m_staged > 1) ? m_staged - 1 : 1;
      if (m_x == 0 && m_y == 0) begin
        m_thick <= m_staged;
        e_thick <= m_staged;
      end else begin
        e_thick <= m_thick;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (bus.vga_rgb !== e_rgb || bus.vga_hs !== e_hs || bus.vga_vs !== e_vs ||
          bus.vga_blank_n !== e_blank || int'(bus.pix_x) != e_px ||
          int'(bus.pix_y) != e_py || int'(bus.thick) != e_thick) begin
        bad++;
        $display("FAIL cycle @%0t: got rgb=%h hs=%b vs=%b bn=%b x=%0d y=%0d t=%0d want rgb=%h hs=%b vs=%b bn=%b x=%0d y=%0d t=%0d",
                 $time, bus.vga_rgb, bus.vga_hs, bus.vga_vs, bus.vga_blank_n, bus.pix_x,
                 bus.pix_y, bus.thick, e_rgb, e_hs, e_vs, e_blank, e_px, e_py, e_thick);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_at(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(bus.pix_x) == x && int'(bus.pix_y) == y) && n < 400);
    check("wait_at_in_time", 32'(n < 400), 32'd1);
  endtask

  task automatic pulse(input logic p, input logic m);
    bus.plus_thick = p;
    bus.minus_thick = m;
    @(negedge clk);
    bus.plus_thick = 1'b0;
    bus.minus_thick = 1'b0;
    @(negedge clk);
  endtask

  // Samples one full frame from the current pixel; counts line-coloured pixels.
  task automatic scan_line(input int lo, input int hi, output int n_line, output int n_off);
    n_line = 0;
    n_off = 0;
    for (int i = 0; i < H_TOT * V_TOT; i++) begin
      if (bus.vga_rgb == LINE) begin
        n_line++;
        if (int'(bus.pix_x) < lo || int'(bus.pix_x) > hi || !bus.vga_blank_n) n_off++;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n_bn, n_hs, n_vs, hs_pos, vs_pos, period, n_line, n_off;
    bus.show_cl = 1'b0;
    bus.plus_thick = 1'b0;
    bus.minus_thick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_hs", bus.vga_hs, 1);
    check("rst_vs", bus.vga_vs, 1);
    check("rst_blank_n", bus.vga_blank_n, 0);
    check("rst_rgb", bus.vga_rgb, 0);
    check("rst_thick", bus.thick, 1);

    // 1: two frames of raw timing
    n_bn = 0; n_hs = 0; n_vs = 0; hs_pos = 0; vs_pos = 0;
    for (int i = 0; i < 2 * H_TOT * V_TOT; i++) begin
      @(negedge clk);
      if (bus.vga_blank_n) n_bn++;
      if (!bus.vga_hs) begin
        n_hs++;
        if (bus.pix_x < 18 || bus.pix_x > 20) hs_pos++;
      end
      if (!bus.vga_vs) begin
        n_vs++;
        if (bus.pix_y != 9 && bus.pix_y != 10) vs_pos++;
      end
    end
    check("blank_n_count", n_bn, 256);
    check("hs_count", n_hs, 72);
    check("hs_position", hs_pos, 0);
    check("vs_count", n_vs, 96);
    check("vs_position", vs_pos, 0);
    wait_at(0, 0);
    period = 0;
    do begin
      @(negedge clk);
      period++;
    end while (!(bus.pix_x == 0 && bus.pix_y == 0) && period < 400);
    check("frame_period", period, 288);

    // 2: centre line, thickness 1
    bus.show_cl = 1'b1;
    wait_at(0, 0);
    scan_line(8, 8, n_line, n_off);
    check("line_t1_count", n_line, 8);
    check("line_t1_place", n_off, 0);

    // 3: two presses mid-frame, then saturation
    wait_at(0, 3);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("thick_held_mid", bus.thick, 1);
    wait_at(23, 11);
    check("thick_held_end", bus.thick, 1);
    @(negedge clk);
    check("thick_loaded", bus.thick, 3);
    scan_line(7, 9, n_line, n_off);
    check("line_t3_count", n_line, 24);
    check("line_t3_place", n_off, 0);
    pulse(1'b1, 1'b0);
    wait_at(0, 0);
    check("thick_sat_max", bus.thick, 3);

    // 4: simultaneous rise, then floor
    wait_at(0, 2);
    pulse(1'b1, 1'b1);
    wait_at(0, 0);
    check("thick_both", bus.thick, 3);
    wait_at(0, 3);
    repeat (4) pulse(1'b0, 1'b1);
    wait_at(0, 0);
    check("thick_floor", bus.thick, 1);
    pulse(1'b1, 1'b0);
    wait_at(0, 0);
    check("thick_two", bus.thick, 2);

    // 5: reset in the middle of both sync pulses
    wait_at(19, 9);
    check("pre_rst_hs", bus.vga_hs, 0);
    check("pre_rst_vs", bus.vga_vs, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_hs", bus.vga_hs, 1);
    check("mid_rst_vs", bus.vga_vs, 1);
    check("mid_rst_blank_n", bus.vga_blank_n, 0);
    check("mid_rst_rgb", bus.vga_rgb, 0);
    check("mid_rst_thick", bus.thick, 1);
    @(negedge clk);
    check("restart_x", bus.pix_x, 0);
    check("restart_y", bus.pix_y, 0);
    check("restart_blank_n", bus.vga_blank_n, 1);

`ifdef VGA_TEST_PATTERN_EN
    // 6: colour bars, no overlay
    bus.show_cl = 1'b0;
    wait_at(0, 0);
    n_off = 0;
    for (int i = 0; i < H_TOT * V_TOT; i++) begin
      if (bus.vga_blank_n && bus.vga_rgb != bars[bus.pix_x / 2]) n_off++;
      @(negedge clk);
    end
    check("bars", n_off, 0);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
